rr_sink_arbiter: RTL and testbench

Round-robin arbiter that shares a single valid/ready sink (such as a rate-limited checker or consumer stage) between N upstream requesters. It registers the granted beat in a one-entry output stage. It tags each beat with its source index. It keeps per-requester delivered-beat counters for bandwidth checks. It sits between the traffic generators and the downstream consumer in the stream test harness.

---
 rtl/rr_sink_arbiter.sv | 117 +++++++++++
 tb/tb_rr_sink_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sink_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink among N requesters, with a one-entry
// registered output stage, source tagging and saturating per-requester delivery counters.
module rr_sink_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16,
    parameter int unsigned SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*DW-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic              down_valid,
    output logic [DW-1:0]     down_data,
    output logic [SW-1:0]     down_src,
    input  logic              down_ready,
    input  logic              clr_cnt,
    output logic [N*CNTW-1:0] accept_cnt
);

    logic            down_valid_q, down_valid_d;
    logic [DW-1:0]   down_data_q, down_data_d;
    logic [SW-1:0]   down_src_q, down_src_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q [N];
    logic [CNTW-1:0] cnt_d [N];

    logic            load_en;
    logic            grant_vld;
    logic [SW-1:0]   grant_idx;
    logic            handshake;

    assign load_en   = !down_valid_q || down_ready;
    assign handshake = down_valid_q && down_ready;

    // First valid requester found scanning upward from ptr, modulo N.
    always_comb begin
        int unsigned   idx;
        logic [SW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx  = (32'(ptr_q) + k) % N;
            cand = SW'(idx);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (load_en && grant_vld) begin
            req_ready = N'(1) << grant_idx;
        end
    end

    always_comb begin
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_src_d   = down_src_q;
        ptr_d        = ptr_q;
        if (load_en) begin
            down_valid_d = grant_vld;
            if (grant_vld) begin
                down_data_d = req_data[grant_idx*DW +: DW];
                down_src_d  = grant_idx;
                ptr_d       = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end
        end
    end

    // Clear has priority over a same-cycle increment; counters saturate.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_cnt) begin
                cnt_d[i] = '0;
            end else if (handshake && (down_src_q == SW'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_src_q   <= '0;
            ptr_q        <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_src_q   <= down_src_d;
            ptr_q        <= ptr_d;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_src   = down_src_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_cnt_out
        assign accept_cnt[gi*CNTW +: CNTW] = cnt_q[gi];
    end

endmodule

// File: tb/tb_rr_sink_arbiter.sv
// Scoreboard bench for rr_sink_arbiter: directed phases plus random traffic against a
// rotating-priority reference model; a monitor checks every delivered beat.
module tb_rr_sink_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int CNTW = 4;
    localparam int SW   = 2;
    localparam int CMAX = (1 << CNTW) - 1;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              down_valid;
    logic [DW-1:0]     down_data;
    logic [SW-1:0]     down_src;
    logic              down_ready;
    logic              clr_cnt;
    logic [N*CNTW-1:0] accept_cnt;

    rr_sink_arbiter #(.N(N), .DW(DW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_src   (down_src),
        .down_ready (down_ready),
        .clr_cnt    (clr_cnt),
        .accept_cnt (accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } beat_t;

    int          vectors;
    int          errors;
    int          delivered;
    beat_t       exp_q[$];
    beat_t       mon_e;
    // Reference model state: what the sink register should hold and who is next in line.
    int          m_ptr;
    bit          m_valid;
    int          m_src;
    int          m_cnt[N];
    logic [DW-1:0] cur_data[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Samples just before the rising edge, when the handshake is decided.
    always @(negedge clk) begin
        #3;
        if (rst === 1'b0 && down_valid === 1'b1 && down_ready === 1'b1) begin
            delivered++;
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL mon_unexpected: got beat %0h src %0d expected none",
                         down_data, down_src);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_data", 64'(down_data), 64'(mon_e.data));
                check("mon_src", 64'(down_src), 64'(mon_e.src));
            end
        end
    end

    // Entered and left at negedge+1. Applies one cycle of inputs and advances the model.
    task automatic step(input logic [N-1:0] v, input bit dr, input bit clr, output int g);
        bit load;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = cur_data[i];
        req_valid  = v;
        down_ready = dr;
        clr_cnt    = clr;
        #1;
        load = !m_valid || dr;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        check("req_ready", 64'(req_ready), (load && g >= 0) ? (64'd1 << g) : 64'd0);
        check("down_valid", 64'(down_valid), 64'(m_valid));
        for (int i = 0; i < N; i++) begin
            check($sformatf("cnt%0d", i), 64'(accept_cnt[i*CNTW +: CNTW]), 64'(m_cnt[i]));
        end
        if (clr) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_valid && dr && m_cnt[m_src] < CMAX) begin
            m_cnt[m_src]++;
        end
        if (!load) begin
            g = -1;
        end else if (g >= 0) begin
            exp_q.push_back({cur_data[g], SW'(g)});
            m_src   = g;
            m_ptr   = (g + 1) % N;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        down_ready = 1'b0;
        clr_cnt    = 1'b0;
        rst        = 1'b1;
        #1;
        check("rst_down_valid", 64'(down_valid), 64'd0);
        check("rst_down_data", 64'(down_data), 64'd0);
        check("rst_down_src", 64'(down_src), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_cnt", 64'(accept_cnt), 64'd0);
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_src   = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int            g;
        int            gs[3];
        int            d0;
        logic [DW-1:0] bp_data;
        logic [N-1:0]  rv;
        vectors    = 0;
        errors     = 0;
        delivered  = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        down_ready = 1'b0;
        clr_cnt    = 1'b0;
        for (int i = 0; i < N; i++) cur_data[i] = $urandom;
        @(negedge clk);
        #1;
        do_reset();

        // Single stream from requester 0.
        for (int b = 0; b < 3; b++) begin
            cur_data[0] = 32'h10 + b;
            step(4'b0001, 1'b1, 1'b0, g);
        end
        step(4'b0000, 1'b1, 1'b0, g);
        step(4'b0000, 1'b1, 1'b0, g);
        check("single_cnt0", 64'(accept_cnt[0 +: CNTW]), 64'd3);

        // Fairness with everyone requesting.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 1'b1, 1'b0, g);
            check("fair_grant", 64'(g), 64'(c % N));
            cur_data[g] = $urandom;
        end
        step(4'b0000, 1'b1, 1'b0, g);
        step(4'b0000, 1'b1, 1'b0, g);
        for (int i = 0; i < N; i++) check("fair_cnt", 64'(accept_cnt[i*CNTW +: CNTW]), 64'd2);

        // Sparse requesters with wrap-around from ptr = 2.
        do_reset();
        step(4'b0001, 1'b1, 1'b0, g);
        step(4'b0010, 1'b1, 1'b0, g);
        for (int c = 0; c < 3; c++) begin
            step(4'b1010, 1'b1, 1'b0, gs[c]);
            cur_data[gs[c]] = $urandom;
        end
        check("sparse_g0", 64'(gs[0]), 64'd3);
        check("sparse_g1", 64'(gs[1]), 64'd1);
        check("sparse_g2", 64'(gs[2]), 64'd3);

        // Backpressure on a beat from requester 2.
        bp_data = cur_data[2];
        step(4'b0100, 1'b1, 1'b0, g);
        cur_data[2] = $urandom;
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b0, 1'b0, g);
            check("bp_data", 64'(down_data), 64'(bp_data));
            check("bp_src", 64'(down_src), 64'd2);
        end
        step(4'b1111, 1'b1, 1'b0, g);
        check("bp_resume", 64'(g), 64'd3);
        cur_data[g] = $urandom;
        d0 = delivered;
        for (int c = 0; c < 12; c++) begin
            step(4'b1111, (c % 3) == 2, 1'b0, g);
            if (g >= 0) cur_data[g] = $urandom;
        end
        check("slow_sink_beats", 64'(delivered - d0), 64'd4);

        // Counter saturation and clear-over-increment.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b0100, 1'b1, 1'b0, g);
            cur_data[2] = $urandom;
        end
        step(4'b0000, 1'b1, 1'b0, g);
        check("sat_cnt2", 64'(accept_cnt[2*CNTW +: CNTW]), 64'(CMAX));
        step(4'b0100, 1'b1, 1'b0, g);
        step(4'b0000, 1'b1, 1'b1, g);
        step(4'b0000, 1'b1, 1'b0, g);
        check("clr_cnt2", 64'(accept_cnt[2*CNTW +: CNTW]), 64'd0);

        // Random traffic obeying hold-until-ready.
        rv = '0;
        for (int c = 0; c < 400; c++) begin
            step(rv, ($urandom % 10) < 7, ($urandom % 32) == 0, g);
            for (int i = 0; i < N; i++) begin
                if (i == g) begin
                    cur_data[i] = $urandom;
                    rv[i]       = 1'($urandom % 2);
                end else if (!rv[i]) begin
                    rv[i] = ($urandom % 3) == 0;
                end
            end
        end

        // Asynchronous reset with a beat in flight.
        step(4'b1111, 1'b1, 1'b0, g);
        do_reset();
        step(4'b1110, 1'b1, 1'b0, g);
        check("post_rst_grant", 64'(g), 64'd1);
        step(4'b0000, 1'b1, 1'b0, g);
        step(4'b0000, 1'b1, 1'b0, g);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
